// File: rtl/adc_fifo_sync_if.sv
// adc_fifo_sync_if: sample FIFO bus between the ADC control side (master) and the FIFO (slave).
interface adc_fifo_sync_if #(parameter int DATA_WIDTH = 14);
    logic                  wr_en;
    logic                  rd_en;
    logic                  overwrite_en;
    logic                  flush;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  empty;
    logic                  full;
    logic [15:0]           adc_fifo_half;
    logic [15:0]           adc_fifo_full;
    logic [15:0]           fifo_real_num;
    logic                  adc_half;
    logic                  adc_full;
    logic                  ovf;
    logic                  udf;
    modport master (
        output wr_en, rd_en, overwrite_en, flush, err_clr, din, adc_fifo_half, adc_fifo_full,
        input  dout, valid, empty, full, fifo_real_num, adc_half, adc_full, ovf, udf
    );
    modport slave (
        input  wr_en, rd_en, overwrite_en, flush, err_clr, din, adc_fifo_half, adc_fifo_full,
        output dout, valid, empty, full, fifo_real_num, adc_half, adc_full, ovf, udf
    );
endinterface

// File: rtl/adc_fifo_sync.sv
// adc_fifo_sync: single-clock ADC sample FIFO with overwrite mode, flush, sticky errors and watermarks.
module adc_fifo_sync #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    adc_fifo_sync_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                  is_empty, is_full, rd_acc, wr_acc, drop, ovf_set, udf_set;
    logic [15:0]           real_num;
    always_comb begin
        is_empty = level_q == '0;
        is_full  = level_q == FULL_LVL;
        rd_acc   = !bus.flush && bus.rd_en && !is_empty;
        wr_acc   = !bus.flush && bus.wr_en && (!is_full || rd_acc || bus.overwrite_en);
        // overwrite on a full FIFO: the write evicts the oldest sample, level unchanged
        drop     = wr_acc && is_full && !rd_acc;
        ovf_set  = !bus.flush && bus.wr_en && is_full && !bus.rd_en;
        udf_set  = !bus.flush && bus.rd_en && is_empty;
        wr_ptr_d = bus.flush ? '0 : wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d = bus.flush ? '0 : rd_ptr_q + ADDR_WIDTH'(rd_acc || drop);
        level_d  = bus.flush ? '0 :
                   (wr_acc && !rd_acc && !drop) ? level_q + ONE :
                   (rd_acc && !wr_acc) ? level_q - ONE : level_q;
        dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
        valid_d  = rd_acc;
        ovf_d    = ovf_set || (ovf_q && !bus.err_clr);
        udf_d    = udf_set || (udf_q && !bus.err_clr);
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
    assign real_num          = 16'(level_q);
    assign bus.fifo_real_num = real_num;
    assign bus.dout          = dout_q;
    assign bus.valid         = valid_q;
    assign bus.empty         = is_empty;
    assign bus.full          = is_full;
    assign bus.adc_half      = real_num >= bus.adc_fifo_half;
    assign bus.adc_full      = real_num >= bus.adc_fifo_full;
    assign bus.ovf           = ovf_q;
    assign bus.udf           = udf_q;
endmodule
